cell_memory_unit: RTL and testbench

//  Responder end of the eval-unit memory interface. Owns the cons-cell store: 24-bit cells {type[23:20], car[19:10], cdr[9:0]}.

---
 rtl/cell_memory_unit.sv | 170 +++++++++++++++++
 tb/tb_cell_memory_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cell_memory_unit.sv
// Cons-cell store answering eval-unit memory requests: cell reads, bump-allocated
// cons writes, and a power-up sweep that clears the free region.
module cell_memory_unit #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 24,
  parameter int FREE_BASE = 'h040,
  parameter logic [FREE_BASE*DATA_W-1:0] IMAGE =
    {{((FREE_BASE-2)*DATA_W){1'b0}}, DATA_W'(24'h000402), DATA_W'(0)}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power,
  input  logic              mem_execute,
  input  logic [1:0]        mem_func,
  input  logic [ADDR_W-1:0] mem_addr0,
  input  logic [ADDR_W-1:0] mem_addr1,
  input  logic [3:0]        mem_type_info,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_full
);

  localparam int                IMG_AW      = $clog2(FREE_BASE);
  localparam logic [ADDR_W-1:0] ERR_ADDR    = '1;
  localparam logic [ADDR_W-1:0] FREE_BASE_A = ADDR_W'(FREE_BASE);
  localparam logic [1:0]        F_GET_CONTENTS = 2'd1;
  localparam logic [1:0]        F_GET_CONS     = 2'd2;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD_WAIT, S_WR, S_RESP} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_free_ptr;
  logic [ADDR_W-1:0]   r_clr_ptr;
  logic [ADDR_W-1:0]   r_addr0;
  logic [ADDR_W-1:0]   r_addr1;
  logic [3:0]          r_type;
  logic                r_is_read;
  logic [1:0]          r_cnt;
  logic [ADDR_W-1:0]   r_resp_addr;
  logic [DATA_W-1:0]   r_resp_data;

  logic [DATA_W-1:0]   r_mem [2**ADDR_W];
  logic [DATA_W-1:0]   r_ram_q;
  logic [DATA_W-1:0]   r_rom_q;

  logic                w_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_cell;
  logic [DATA_W-1:0]   w_rd_data;
  logic [DATA_W-1:0]   w_image [FREE_BASE];

  // The program image is a constant table overlaying the low cells; neither INIT
  // nor the allocator ever addresses below FREE_BASE, so it is never disturbed.
  genvar gi;
  generate
    for (gi = 0; gi < FREE_BASE; gi++) begin : g_image
      assign w_image[gi] = IMAGE[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_cell = {r_type, r_addr0, r_addr1};

  always_comb begin
    w_we       = 1'b0;
    w_ram_addr = r_addr0;
    w_wdata    = '0;
    case (r_state)
      S_INIT: begin
        w_ram_addr = r_clr_ptr;
        w_we       = rst && power && (r_clr_ptr != ERR_ADDR);
      end
      S_WR: begin
        w_ram_addr = r_free_ptr;
        w_wdata    = w_cell;
        w_we       = rst && power && (r_free_ptr != ERR_ADDR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_ram_addr] <= w_wdata;
    r_ram_q <= r_mem[w_ram_addr];
    r_rom_q <= w_image[w_ram_addr[IMG_AW-1:0]];
  end

  assign w_rd_data = (r_addr0 == ERR_ADDR)   ? '0      :
                     (r_addr0 < FREE_BASE_A) ? r_rom_q : r_ram_q;

  // r_cnt pads every request to the same latency, whichever path it takes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_INIT;
      r_free_ptr  <= FREE_BASE_A;
      r_clr_ptr   <= FREE_BASE_A;
      r_addr0     <= '0;
      r_addr1     <= '0;
      r_type      <= '0;
      r_is_read   <= 1'b0;
      r_cnt       <= '0;
      r_resp_addr <= '0;
      r_resp_data <= '0;
      mem_ready   <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_full    <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      if (power) begin
        case (r_state)
          S_INIT: begin
            if (r_clr_ptr == ERR_ADDR) begin
              mem_ready <= 1'b1;
              mem_addr  <= '0;
              mem_data  <= '0;
              r_state   <= S_IDLE;
            end else begin
              r_clr_ptr <= r_clr_ptr + 1'b1;
            end
          end
          S_IDLE: begin
            if (mem_execute) begin
              r_addr0     <= mem_addr0;
              r_addr1     <= mem_addr1;
              r_type      <= mem_type_info;
              r_is_read   <= (mem_func == F_GET_CONTENTS);
              r_cnt       <= '0;
              r_resp_addr <= ERR_ADDR;
              r_resp_data <= '0;
              case (mem_func)
                F_GET_CONTENTS: r_state <= S_RD_WAIT;
                F_GET_CONS:     r_state <= S_WR;
                default:        r_state <= S_RESP;
              endcase
            end
          end
          S_RD_WAIT: begin
            r_cnt   <= r_cnt + 2'd1;
            r_state <= S_RESP;
          end
          S_WR: begin
            r_cnt <= r_cnt + 2'd1;
            if (r_free_ptr != ERR_ADDR) begin
              r_resp_addr <= r_free_ptr;
              r_resp_data <= w_cell;
              r_free_ptr  <= r_free_ptr + 1'b1;
            end else begin
              mem_full <= 1'b1;
            end
            r_state <= S_RESP;
          end
          S_RESP: begin
            if (r_cnt == 2'd2) begin
              mem_ready <= 1'b1;
              mem_addr  <= r_is_read ? r_addr0 : r_resp_addr;
              mem_data  <= r_is_read ? w_rd_data : r_resp_data;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
          default: r_state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cell_memory_unit.sv
// Directed plus randomized bench for cell_memory_unit, checked against an
// array model of the cell store and bump allocator.
module tb_cell_memory_unit;

  localparam int         AW  = 10;
  localparam int         DW  = 24;
  localparam int         FB  = 'h040;
  localparam logic [9:0] ERR = 10'h3FF;

  function automatic logic [DW-1:0] img_cell(input int i);
    if (i == 1) return 24'h000402;
    return 24'((i * 40503) ^ 'h530000);
  endfunction

  function automatic logic [FB*DW-1:0] build_image();
    logic [FB*DW-1:0] v;
    v = '0;
    for (int i = 0; i < FB; i++) v[i*DW +: DW] = img_cell(i);
    return v;
  endfunction

  localparam logic [FB*DW-1:0] TB_IMAGE = build_image();

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          power = 1'b1;
  logic          mem_execute = 1'b0;
  logic [1:0]    mem_func = '0;
  logic [AW-1:0] mem_addr0 = '0;
  logic [AW-1:0] mem_addr1 = '0;
  logic [3:0]    mem_type_info = '0;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_full;

  cell_memory_unit #(
    .ADDR_W(AW), .DATA_W(DW), .FREE_BASE(FB), .IMAGE(TB_IMAGE)
  ) dut (
    .clk(clk), .rst(rst), .power(power), .mem_execute(mem_execute),
    .mem_func(mem_func), .mem_addr0(mem_addr0), .mem_addr1(mem_addr1),
    .mem_type_info(mem_type_info), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_full(mem_full)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_mem [1024];
  logic [AW-1:0] exp_free;
  logic          exp_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) exp_mem[i] = (i < FB) ? img_cell(i) : '0;
    exp_free = 10'(FB);
    exp_full = 1'b0;
  endtask

  task automatic wait_init();
    int lat;
    int pulses;
    lat = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) begin lat = k; break; end
    end
    chk("init_latency", 32'(lat), 32'd960);
    chk("init_addr", 32'(mem_addr), 32'd0);
    chk("init_data", 32'(mem_data), 32'd0);
    chk("init_full", 32'(mem_full), 32'd0);
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (mem_ready === 1'b1) pulses++;
    end
    chk("init_single_pulse", 32'(pulses), 32'd0);
    $display("init: ready after %0d cycles", lat);
  endtask

  task automatic request(input logic [1:0] f, input logic [AW-1:0] x0, input logic [AW-1:0] x1,
                         input logic [3:0] t, input bit junk, input int pwr_off);
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int lat;
    int pulses;
    if (f == 2'd1) begin
      e_addr = x0;
      e_data = (x0 == ERR) ? '0 : exp_mem[x0];
    end else if (f == 2'd2 && exp_free != ERR) begin
      e_addr = exp_free;
      e_data = {t, x0, x1};
      exp_mem[exp_free] = e_data;
      exp_free = exp_free + 1'b1;
    end else begin
      if (f == 2'd2) exp_full = 1'b1;
      e_addr = ERR;
      e_data = '0;
    end
    @(negedge clk);
    mem_func = f; mem_addr0 = x0; mem_addr1 = x1; mem_type_info = t;
    mem_execute = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_execute = junk;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (pwr_off > 0 && k == 1) power = 1'b0;
      if (pwr_off > 0 && k == 1 + pwr_off) power = 1'b1;
      @(posedge clk); #1;
      if (mem_ready === 1'b1) begin lat = k; break; end
      @(negedge clk);
      mem_execute = junk && (k + 1 <= 3);
    end
    chk("req_latency", 32'(lat), 32'(3 + pwr_off));
    chk("req_addr", 32'(mem_addr), 32'(e_addr));
    chk("req_data", 32'(mem_data), 32'(e_data));
    chk("req_full", 32'(mem_full), 32'(exp_full));
    @(negedge clk);
    mem_execute = 1'b0;
    @(posedge clk); #1;
    chk("ready_one_cycle", 32'(mem_ready), 32'd0);
    if (junk) begin
      pulses = 0;
      repeat (4) begin
        @(posedge clk); #1;
        if (mem_ready === 1'b1) pulses++;
      end
      chk("junk_ignored", 32'(pulses), 32'd0);
    end
    $display("req func=%0d a0=%03h a1=%03h type=%0h -> addr=%03h data=%06h lat=%0d",
             f, x0, x1, t, mem_addr, mem_data, lat);
  endtask

  initial begin
    logic [1:0]    f;
    logic [AW-1:0] ra;
    int            sel;

    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_data", 32'(mem_data), 32'd0);
    chk("rst_full", 32'(mem_full), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    wait_init();

    request(2'd1, 10'h001, '0, '0, 0, 0);
    request(2'd2, 10'h009, 10'h050, 4'd5, 0, 0);
    request(2'd1, 10'h040, '0, '0, 0, 0);
    request(2'd2, 10'($urandom), 10'($urandom), 4'($urandom), 0, 0);
    request(2'd1, 10'h041, '0, '0, 1, 0);
    request(2'd2, 10'h123, 10'h3AB, 4'hC, 1, 0);
    request(2'd3, 10'h010, 10'h020, 4'h1, 0, 0);
    request(2'd0, 10'h011, 10'h021, 4'h2, 1, 0);
    request(2'd1, ERR, '0, '0, 0, 0);
    request(2'd1, 10'h040, '0, '0, 0, 10);

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      f = (sel < 4) ? 2'd1 : (sel < 8) ? 2'd2 : (sel == 8) ? 2'd0 : 2'd3;
      ra = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 'h05F)) : 10'($urandom);
      request(f, ra, 10'($urandom), 4'($urandom), 0, 0);
    end

    while (exp_free != ERR) request(2'd2, 10'($urandom), 10'($urandom), 4'($urandom), 0, 0);
    request(2'd2, 10'h055, 10'h066, 4'h7, 0, 0);
    request(2'd1, 10'h3FE, '0, '0, 0, 0);
    for (int i = 0; i < 8; i++) request(2'd1, 10'($urandom), '0, '0, 0, 0);
    request(2'd2, 10'h077, 10'h088, 4'h9, 0, 0);

    @(negedge clk);
    mem_func = 2'd2; mem_addr0 = 10'h001; mem_addr1 = 10'h002; mem_type_info = 4'h3;
    mem_execute = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_execute = 1'b0;
    rst = 1'b0;
    #1;
    chk("midwr_rst_ready", 32'(mem_ready), 32'd0);
    chk("midwr_rst_addr", 32'(mem_addr), 32'd0);
    chk("midwr_rst_data", 32'(mem_data), 32'd0);
    chk("midwr_rst_full", 32'(mem_full), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    wait_init();
    request(2'd1, 10'h100, '0, '0, 0, 0);
    request(2'd1, 10'h001, '0, '0, 0, 0);
    request(2'd1, 10'h03F, '0, '0, 0, 0);
    request(2'd2, 10'h00A, 10'h00B, 4'h4, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
